// File: rtl/median_stream_filter.sv
// Streaming sliding-window median filter with a registered valid/ready output.
// Keeps the last WINDOW samples in age order (win) and in value order (srt) so
// the median is a fixed index into the sorted array.
// Optional feature: define MEDIAN_EDGE_REPLICATE_EN to seed the whole window
// with the first sample after reset or clear instead of waiting for it to fill.
module median_stream_filter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_median,
  output logic [$clog2(WINDOW+1)-1:0]   fill_cnt
);

  localparam int unsigned CntW   = $clog2(WINDOW + 1);
  localparam int          Win    = int'(WINDOW);
  localparam int          MidIdx = (Win - 1) / 2;

  if (WINDOW < 3 || WINDOW > 15 || (WINDOW % 2) == 0) begin : gen_window_check
    $error("median_stream_filter: WINDOW must be odd and within 3..15");
  end

  logic [WIDTH-1:0] win_q [Win];
  logic [WIDTH-1:0] win_d [Win];
  logic [WIDTH-1:0] srt_q [Win];
  logic [WIDTH-1:0] srt_d [Win];
  logic [WIDTH-1:0] lst   [Win];
  logic [WIDTH-1:0] srt_ins [Win];
  logic [CntW-1:0]  fill_cnt_q, fill_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_median_q, out_median_d;
  logic             accept;
  logic             full;
  int               rm_idx;
  int               lst_len;
  int               ins_pos;

  // clear blocks intake so a sample offered alongside it is dropped
  assign in_ready   = !clear && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign full       = (fill_cnt_q == CntW'(Win));
  assign out_valid  = out_valid_q;
  assign out_median = out_median_q;
  assign fill_cnt   = fill_cnt_q;

  // Sorted insert: build the surviving sorted list, then slot in_data after equals
  always_comb begin
    rm_idx = 0;
    for (int i = Win - 1; i >= 0; i--) begin
      if (srt_q[i] == win_q[Win-1]) rm_idx = i;
    end

    if (full) begin
      // drop the first copy of the oldest sample; any equal copy is interchangeable
      lst_len = Win - 1;
      for (int i = 0; i < Win - 1; i++) begin
        lst[i] = (i < rm_idx) ? srt_q[i] : srt_q[i+1];
      end
      lst[Win-1] = srt_q[Win-1];
    end else begin
      lst_len = int'(fill_cnt_q);
      lst     = srt_q;
    end

    ins_pos = 0;
    for (int i = 0; i < Win; i++) begin
      if (i < lst_len && lst[i] <= in_data) ins_pos = ins_pos + 1;
    end

    srt_ins[0] = (ins_pos == 0) ? in_data : lst[0];
    for (int i = 1; i < Win; i++) begin
      if (i < ins_pos)       srt_ins[i] = lst[i];
      else if (i == ins_pos) srt_ins[i] = in_data;
      else                   srt_ins[i] = lst[i-1];
    end
  end

  // Next-state: window/sorted update, fill count and output register
  always_comb begin
    win_d        = win_q;
    srt_d        = srt_q;
    fill_cnt_d   = fill_cnt_q;
    out_valid_d  = out_valid_q;
    out_median_d = out_median_q;

    if (clear) begin
      fill_cnt_d  = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
`ifdef MEDIAN_EDGE_REPLICATE_EN
      if (fill_cnt_q == '0) begin
        for (int i = 0; i < Win; i++) begin
          win_d[i] = in_data;
          srt_d[i] = in_data;
        end
        fill_cnt_d   = CntW'(Win);
        out_valid_d  = 1'b1;
        out_median_d = in_data;
      end else
`endif
      begin
        win_d[0] = in_data;
        for (int i = 1; i < Win; i++) win_d[i] = win_q[i-1];
        srt_d = srt_ins;
        if (!full) fill_cnt_d = fill_cnt_q + CntW'(1);
        if (full || fill_cnt_q == CntW'(Win - 1)) begin
          out_valid_d  = 1'b1;
          out_median_d = srt_ins[MidIdx];
        end else begin
          // accept implies any old output was taken this edge
          out_valid_d = 1'b0;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Win; i++) begin
        win_q[i] <= '0;
        srt_q[i] <= '0;
      end
      fill_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_median_q <= '0;
    end else begin
      win_q        <= win_d;
      srt_q        <= srt_d;
      fill_cnt_q   <= fill_cnt_d;
      out_valid_q  <= out_valid_d;
      out_median_q <= out_median_d;
    end
  end

endmodule

// File: tb/tb_median_stream_filter.sv
// Bench for median_stream_filter: a WINDOW=3 and a WINDOW=5 instance checked each
// cycle against a queue-and-sort reference model, plus directed scenarios.
// Honors MEDIAN_EDGE_REPLICATE_EN in the model and directed section.
module tb_median_stream_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear     [2];
  logic       in_valid  [2];
  logic       out_ready [2];
  logic [7:0] in_data   [2];
  logic       in_ready  [2];
  logic       out_valid [2];
  logic [7:0] out_median[2];
  logic [1:0] fill3;
  logic [2:0] fill5;

  always #5 clk = ~clk;

  median_stream_filter #(.WIDTH(8), .WINDOW(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_median(out_median[0]), .fill_cnt(fill3)
  );

  median_stream_filter #(.WIDTH(8), .WINDOW(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_median(out_median[1]), .fill_cnt(fill5)
  );

  // Reference model: newest-first sample list per instance
  int mwin [2][16];
  int mcnt [2];
  bit mov  [2];
  int mmed [2];
  int n_cmp = 0;
  int n_err = 0;

  function automatic int win_of(input int k);
    return (k == 0) ? 3 : 5;
  endfunction

  function automatic logic [31:0] fill_of(input int k);
    return (k == 0) ? 32'(fill3) : 32'(fill5);
  endfunction

  function automatic int median(input int k);
    int t[16];
    int n;
    int x;
    n = mcnt[k];
    for (int i = 0; i < n; i++) t[i] = mwin[k][i];
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n - 1 - i; j++)
        if (t[j] > t[j+1]) begin
          x = t[j]; t[j] = t[j+1]; t[j+1] = x;
        end
    return t[(n-1)/2];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      mov[k]  = 0;
      mmed[k] = 0;
    end
  endtask

  task automatic check_outputs();
    bit exp_ir;
    for (int k = 0; k < 2; k++) begin
      exp_ir = !clear[k] && (!mov[k] || out_ready[k]);
      check($sformatf("in_ready[%0d]", k), 32'(in_ready[k]), 32'(exp_ir));
      check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(mov[k]));
      check($sformatf("fill_cnt[%0d]", k), fill_of(k), 32'(mcnt[k]));
      if (mov[k]) check($sformatf("out_median[%0d]", k), 32'(out_median[k]), 32'(mmed[k]));
    end
  endtask

  // Apply this cycle's inputs to the model (state as of the coming edge)
  task automatic model_update();
    bit ir;
    bit acc;
    bit rep;
    int w;
    for (int k = 0; k < 2; k++) begin
      w   = win_of(k);
      ir  = !clear[k] && (!mov[k] || out_ready[k]);
      acc = in_valid[k] && ir;
      rep = 0;
      if (clear[k]) begin
        mcnt[k] = 0;
        mov[k]  = 0;
      end else if (acc) begin
`ifdef MEDIAN_EDGE_REPLICATE_EN
        rep = (mcnt[k] == 0);
`endif
        if (rep) begin
          for (int i = 0; i < w; i++) mwin[k][i] = int'(in_data[k]);
          mcnt[k] = w;
        end else begin
          for (int i = w - 1; i > 0; i--) mwin[k][i] = mwin[k][i-1];
          mwin[k][0] = int'(in_data[k]);
          if (mcnt[k] < w) mcnt[k]++;
        end
        if (mcnt[k] == w) begin
          mov[k]  = 1;
          mmed[k] = median(k);
        end else begin
          mov[k] = 0;
        end
      end else if (out_ready[k]) begin
        mov[k] = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int k, input int d);
    in_valid[k] = 1'b1;
    in_data[k]  = 8'(d);
    step();
    in_valid[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      clear[k] = 0; in_valid[k] = 0; out_ready[k] = 1; in_data[k] = '0;
    end
    model_reset();
    #12;
    check("reset_in_ready", 32'(in_ready[0]), 32'd1);
    check("reset_out_valid", 32'(out_valid[1]), 32'd0);
    check("reset_median", 32'(out_median[0]), 32'd0);
    check("reset_fill", 32'(fill5), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef MEDIAN_EDGE_REPLICATE_EN
    feed(0, 'h40);
    check("rep_first", 32'(out_median[0]), 32'h40);
    check("rep_first_v", 32'(out_valid[0]), 32'd1);
    feed(0, 'h02);
    check("rep_second", 32'(out_median[0]), 32'h40);
    feed(0, 'h08);
    check("rep_third", 32'(out_median[0]), 32'h08);
`else
    // WINDOW=3 basic fill and slide
    feed(0, 'h20);
    feed(0, 'h80);
    check("w3_no_early", 32'(out_valid[0]), 32'd0);
    feed(0, 'h04);
    check("w3_out0", 32'(out_median[0]), 32'h20);
    feed(0, 'h10);
    check("w3_out1", 32'(out_median[0]), 32'h10);
    feed(0, 'h40);
    check("w3_out2", 32'(out_median[0]), 32'h10);

    // WINDOW=5 with duplicates
    feed(1, 'h01); feed(1, 'h08); feed(1, 'h20); feed(1, 'h02);
    check("w5_no_early", 32'(out_valid[1]), 32'd0);
    feed(1, 'h40);
    check("w5_out0", 32'(out_median[1]), 32'h08);
    feed(1, 'h10);
    check("w5_out1", 32'(out_median[1]), 32'h10);
    for (int i = 0; i < 3; i++) begin
      feed(1, 'h10);
      check("w5_dup", 32'(out_median[1]), 32'h10);
    end

    // Backpressure: hold output for 10 cycles, then release
    clear[0] = 1; step(); clear[0] = 0;
    feed(0, 'h20); feed(0, 'h80);
    out_ready[0] = 0;
    feed(0, 'h04);
    check("bp_first", 32'(out_median[0]), 32'h20);
    in_valid[0] = 1; in_data[0] = 8'h55;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold", 32'(out_median[0]), 32'h20);
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    out_ready[0] = 1;
    step();
    check("bp_release", 32'(out_median[0]), 32'h55);

    // clear with a pending output and a sample offered
    in_valid[0] = 0; out_ready[0] = 0;
    step();
    check("clr_pending", 32'(out_valid[0]), 32'd1);
    clear[0] = 1; in_valid[0] = 1; in_data[0] = 8'h99;
    check("clr_in_ready", 32'(in_ready[0]), 32'd0);
    step();
    check("clr_out_valid", 32'(out_valid[0]), 32'd0);
    check("clr_fill", 32'(fill3), 32'd0);
    clear[0] = 0; in_valid[0] = 0; out_ready[0] = 1;
`endif

    // Asynchronous reset mid-stream
    feed(1, 'h11); feed(1, 'h22); feed(1, 'h33);
    feed(0, 'h05); feed(0, 'h06); feed(0, 'h07);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid[0]), 32'd0);
    check("arst_fill3", 32'(fill3), 32'd0);
    check("arst_fill5", 32'(fill5), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    feed(0, 'h09); feed(0, 'h01);
`ifndef MEDIAN_EDGE_REPLICATE_EN
    check("arst_refill", 32'(out_valid[0]), 32'd0);
`endif
    feed(0, 'h03);
    check("arst_after", 32'(out_valid[0]), 32'd1);

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 9) < 7);
        in_data[k]   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
        out_ready[k] = ($urandom_range(0, 3) != 0);
        clear[k]     = ($urandom_range(0, 59) == 0);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 0; clear[k] = 0; out_ready[k] = 1;
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
